// File: rtl/flash_read_pkg.sv
// flash_read_pkg: shared types, widths and byte-lane masking for the flash read controller
package flash_read_pkg;
  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;
  localparam logic [5:0] FLASH_BURST = 6'd1;
  localparam int FLASH_TIMEOUT = 255;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, DONE, REARM} state_t;
  function automatic logic [FLASH_DATA_W-1:0] byte_mask(input logic [FLASH_DATA_W-1:0] d, input logic [3:0] be);
    logic [FLASH_DATA_W-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
    return m;
  endfunction
endpackage

// File: rtl/flash_timeout_counter.sv
// flash_timeout_counter: saturating cycle counter that flags when LIMIT is reached
module flash_timeout_counter #(
  parameter int LIMIT = 255,
  parameter int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (reset || clear) count <= '0;
    else if (enable && count != '1) count <= count + W'(1);
  assign expired = count == W'(LIMIT);
endmodule

// File: rtl/flash_read_ctrl.sv
// flash_read_ctrl: turns a held start_flash/read request into one Avalon-MM pipelined flash read
module flash_read_ctrl
  import flash_read_pkg::*;
#(
  parameter int ADDR_W = FLASH_ADDR_W,
  parameter int DATA_W = FLASH_DATA_W,
  parameter int TIMEOUT_CYCLES = FLASH_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_flash,
  input  logic              read,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        byteenable,
  output logic              end_flash_read,
  output logic [DATA_W-1:0] audiodata,
  output logic              busy,
  output logic              timeout_err,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  output logic [5:0]        flash_mem_burstcount,
  input  logic              flash_mem_waitrequest,
  input  logic [DATA_W-1:0] flash_mem_readdata,
  input  logic              flash_mem_readdatavalid
);
  state_t state;
  logic expired;
  assign flash_mem_burstcount = FLASH_BURST;
  flash_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .enable(state == ISSUE || state == WAIT_DATA),
    .expired(expired)
  );
  // Timeout wins over a same-cycle accept or data beat; audiodata is left alone on timeout
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      end_flash_read <= 1'b0;
      flash_mem_read <= 1'b0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
      audiodata <= '0;
      flash_mem_address <= '0;
      flash_mem_byteenable <= '0;
    end else begin
      end_flash_read <= 1'b0;
      case (state)
        IDLE: if (start_flash && read) begin
          flash_mem_address <= mem_addr;
          flash_mem_byteenable <= byteenable;
          timeout_err <= 1'b0;
          flash_mem_read <= 1'b1;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (expired) begin
          timeout_err <= 1'b1;
          flash_mem_read <= 1'b0;
          end_flash_read <= 1'b1;
          state <= DONE;
        end else if (!flash_mem_waitrequest) begin
          flash_mem_read <= 1'b0;
          state <= WAIT_DATA;
        end
        WAIT_DATA: if (expired) begin
          timeout_err <= 1'b1;
          end_flash_read <= 1'b1;
          state <= DONE;
        end else if (flash_mem_readdatavalid) begin
          audiodata <= byte_mask(flash_mem_readdata, flash_mem_byteenable);
          end_flash_read <= 1'b1;
          state <= DONE;
        end
        DONE: state <= REARM;
        REARM: if (!start_flash) begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_flash_read_ctrl.sv
// tb_flash_read_ctrl: table-driven and randomized reads against a cycle-count reference model
module tb_flash_read_ctrl;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic reset, start_flash, read;
  logic [22:0] mem_addr;
  logic [3:0] byteenable;
  logic end_flash_read, busy, timeout_err, flash_mem_read;
  logic [31:0] audiodata, flash_mem_readdata;
  logic [22:0] flash_mem_address;
  logic [3:0] flash_mem_byteenable;
  logic [5:0] flash_mem_burstcount;
  logic flash_mem_waitrequest, flash_mem_readdatavalid;
  int total = 0;
  int bad = 0;
  logic [31:0] prev_data;

  typedef struct {
    logic [22:0] addr;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          w;
    int          d;
    bit          never;
    int          hold;
    logic [31:0] exp_data;
    bit          exp_to;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  flash_read_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .start_flash(start_flash),
    .read(read),
    .mem_addr(mem_addr),
    .byteenable(byteenable),
    .end_flash_read(end_flash_read),
    .audiodata(audiodata),
    .busy(busy),
    .timeout_err(timeout_err),
    .flash_mem_read(flash_mem_read),
    .flash_mem_address(flash_mem_address),
    .flash_mem_byteenable(flash_mem_byteenable),
    .flash_mem_burstcount(flash_mem_burstcount),
    .flash_mem_waitrequest(flash_mem_waitrequest),
    .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask_ref(input logic [31:0] d, input logic [3:0] be);
    longint unsigned r = 0;
    longint unsigned x = d;
    for (int i = 0; i < 4; i++)
      if (be[i]) r += ((x / (longint'(1) << (8 * i))) % 256) * (longint'(1) << (8 * i));
    return r[31:0];
  endfunction

  // Cycle k counts from the first cycle flash_mem_read is seen high; data beat lands on k = w+1+d
  task automatic run_read(input string tag, input logic [22:0] a, input logic [3:0] b,
                          input logic [31:0] rd, input int w, input int d, input bit never,
                          input int hold, input logic [31:0] exp_data, input bit exp_to);
    int k = -1;
    int rd_cycles = 0;
    int accepts = 0;
    int k_end = -1;
    int addr_bad = 0;
    int hb = 0;
    int v = w + 1 + d;
    start_flash = 1'b1;
    read = 1'b1;
    mem_addr = a;
    byteenable = b;
    for (int c = 0; c < 60 && k_end < 0; c++) begin
      tick;
      if (k >= 0) k++;
      else if (flash_mem_read) k = 0;
      if (k >= 0) begin
        mem_addr = 23'($urandom);
        byteenable = 4'($urandom);
      end
      if (flash_mem_read) begin
        rd_cycles++;
        if (flash_mem_address !== a || flash_mem_byteenable !== b) addr_bad++;
        if (!(k < w)) accepts++;
      end
      if (end_flash_read) k_end = k;
      flash_mem_waitrequest = (k >= 0) && (k < w);
      flash_mem_readdatavalid = (k >= 0) && !never && k == v;
      flash_mem_readdata = flash_mem_readdatavalid ? rd : $urandom;
    end
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    check({tag, " end_cycle"}, 64'(k_end), 64'(exp_to ? TMO + 1 : v + 1));
    check({tag, " read_cycles"}, 64'(rd_cycles), 64'((w < TMO ? w : TMO) + 1));
    check({tag, " accepts"}, 64'(accepts), 64'd1);
    check({tag, " addr_stable"}, 64'(addr_bad), 64'd0);
    check({tag, " audiodata"}, 64'(audiodata), 64'(exp_data));
    check({tag, " timeout_err"}, 64'(timeout_err), 64'(exp_to));
    prev_data = exp_data;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (flash_mem_read || end_flash_read || !busy) hb++;
    end
    check({tag, " held_start"}, 64'(hb), 64'd0);
    start_flash = 1'b0;
    read = 1'b0;
    tick;
    check({tag, " end_one_cycle"}, 64'(end_flash_read), 64'd0);
    tick;
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ign;
    vecs[0] = '{23'h00010, 4'hF, 32'hDEADBEEF, 0, 1, 0, 0, 32'hDEADBEEF, 0};
    vecs[1] = '{23'h12345, 4'hF, 32'h01234567, 5, 0, 0, 0, 32'h01234567, 0};
    vecs[2] = '{23'h7FFFFF, 4'b0011, 32'hAABBCCDD, 0, 0, 0, 10, 32'h0000CCDD, 0};
    vecs[3] = '{23'h00ABC, 4'hF, 32'h55555555, 0, 0, 1, 0, 32'h0000CCDD, 1};
    vecs[4] = '{23'h00001, 4'b1010, 32'h11223344, 2, 3, 0, 0, 32'h11003300, 0};
    vecs[5] = '{23'h00005, 4'b0100, 32'hCAFEF00D, 3, 11, 0, 0, 32'h00FE0000, 0};
    vecs[6] = '{23'h00006, 4'hF, 32'h12121212, 3, 12, 0, 0, 32'h00FE0000, 1};
    reset = 1'b1;
    start_flash = 1'b0;
    read = 1'b0;
    mem_addr = '0;
    byteenable = '0;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = '0;
    prev_data = '0;
    tick;
    tick;
    reset = 1'b0;
    check("rst end", 64'(end_flash_read), 0);
    check("rst read", 64'(flash_mem_read), 0);
    check("rst busy", 64'(busy), 0);
    check("rst timeout", 64'(timeout_err), 0);
    check("rst audiodata", 64'(audiodata), 0);
    check("rst address", 64'(flash_mem_address), 0);
    check("rst byteenable", 64'(flash_mem_byteenable), 0);
    check("rst burstcount", 64'(flash_mem_burstcount), 1);
    // start_flash without read must not start anything
    start_flash = 1'b1;
    mem_addr = 23'h333;
    ign = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (flash_mem_read || busy) ign++;
    end
    start_flash = 1'b0;
    check("no_read_qualifier", 64'(ign), 0);
    for (int i = 0; i < 7; i++)
      run_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].be, vecs[i].rdata, vecs[i].w,
               vecs[i].d, vecs[i].never, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_to);
    // reset during WAIT_DATA, then a late data beat that must be ignored
    start_flash = 1'b1;
    read = 1'b1;
    mem_addr = 23'h4444;
    byteenable = 4'hF;
    tick;
    tick;
    check("mr in_wait_data", 64'({flash_mem_read, busy}), 64'b01);
    reset = 1'b1;
    start_flash = 1'b0;
    read = 1'b0;
    tick;
    reset = 1'b0;
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata = 32'h98765432;
    ign = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      flash_mem_readdatavalid = 1'b0;
      if (end_flash_read || busy || flash_mem_read) ign++;
    end
    check("mr no_activity", 64'(ign), 0);
    check("mr audiodata", 64'(audiodata), 0);
    check("mr timeout", 64'(timeout_err), 0);
    check("mr address", 64'(flash_mem_address), 0);
    check("mr byteenable", 64'(flash_mem_byteenable), 0);
    prev_data = '0;
    for (int i = 0; i < 20; i++) begin
      logic [22:0] a;
      logic [3:0] b;
      logic [31:0] rd;
      int w, d, hold;
      bit never, succ;
      a = 23'($urandom);
      b = 4'($urandom);
      rd = $urandom;
      w = $urandom_range(0, 10);
      d = $urandom_range(0, 8);
      never = $urandom_range(0, 9) == 0;
      hold = $urandom_range(0, 3);
      succ = !never && (w + 1 + d) < TMO;
      run_read($sformatf("rnd%0d", i), a, b, rd, w, d, never, hold,
               succ ? mask_ref(rd, b) : prev_data, !succ);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_read_ctrl.md
Name: flash_read_ctrl

Overview:
- Responder side of the single-word flash read handshake used by the audio address calculator.
- Accepts a read request (start_flash/read with mem_addr, byteenable) and drives one Avalon-MM pipelined read on the flash controller's data port.
- Returns the 32-bit word on audiodata and pulses end_flash_read for one clock.
- Sits between the address calculator and the on-board flash IP, clocked by the 50 MHz system clock.

Parameters:
- ADDR_W, 23, word address width on both interfaces.
- DATA_W, 32, flash data width.
- TIMEOUT_CYCLES, 255, maximum clocks from command issue to readdatavalid before the read is abandoned.

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- start_flash  in  1  request strobe; requester holds it high until it sees end_flash_read.
- read  in  1  read qualifier; a request counts only when start_flash && read.
- mem_addr  in  ADDR_W  word address of the request.
- byteenable  in  4  byte lanes requested.
- end_flash_read  out  1  one-cycle completion pulse.
- audiodata  out  DATA_W  returned word, masked by byteenable.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky flag for the last request that timed out.
- flash_mem_read  out  1  Avalon read command.
- flash_mem_address  out  ADDR_W  Avalon address.
- flash_mem_byteenable  out  4  Avalon byteenable.
- flash_mem_burstcount  out  6  constant 1.
- flash_mem_waitrequest  in  1  Avalon stall.
- flash_mem_readdata  in  DATA_W  Avalon read data.
- flash_mem_readdatavalid  in  1  Avalon data strobe.

Behaviour:
- Reset values:
  - state IDLE.
  - end_flash_read=0, flash_mem_read=0, busy=0, timeout_err=0.
  - audiodata=0, flash_mem_address=0, flash_mem_byteenable=0.
  - Timeout counter=0.
  - burstcount is always 1.
- Reset asserted mid-operation: returns to IDLE at the next edge and drops flash_mem_read. A late readdatavalid after that is ignored.
- All outputs are registered; none is combinational from inputs.
- IDLE:
  - On start_flash && read: latch mem_addr and byteenable into flash_mem_address/flash_mem_byteenable, clear timeout_err and the counter, go ISSUE.
  - start_flash without read is ignored.
- ISSUE:
  - flash_mem_read=1 with address and byteenable stable.
  - Counter increments each cycle.
  - A cycle with flash_mem_read=1 and waitrequest=0 accepts the command: deassert read next edge, go WAIT_DATA.
- WAIT_DATA:
  - flash_mem_read=0, counter increments.
  - On readdatavalid: audiodata <= readdata with bytes whose byteenable bit is 0 forced to 0x00, go DONE.
  - readdatavalid outside WAIT_DATA is ignored.
- Timeout, in ISSUE or WAIT_DATA: when the counter reaches TIMEOUT_CYCLES, set timeout_err=1, drop flash_mem_read, leave audiodata unchanged (avoids an audible click), go DONE.
- DONE: end_flash_read=1 for exactly this one cycle, then go REARM.
- REARM:
  - Wait until start_flash=0, then go IDLE.
  - A requester that holds start_flash high therefore never triggers a second read.
- Minimum latency (accept at edge T, waitrequest=0, readdatavalid on the first cycle after command acceptance):
  - flash_mem_read high in cycle T+1.
  - readdatavalid in T+2.
  - audiodata valid and end_flash_read high in T+3.
- audiodata holds its value until the next successful capture.
- Counter is 8 bits wide (ceil log2(TIMEOUT_CYCLES+1)) and saturates; no wrap.

Decomposition:
- Package flash_read_pkg:
  - State enum IDLE/ISSUE/WAIT_DATA/DONE/REARM.
  - FLASH_ADDR_W=23, FLASH_DATA_W=32, FLASH_BURST=6'd1, default TIMEOUT_CYCLES.
  - Byte-mask function.
- Sub-module: flash_timeout_counter (clear, enable, saturating count, expired flag).

Test Plan:
- Basic read: request mem_addr=23'h00010, byteenable=4'hF; waitrequest=0; readdatavalid with 32'hDEAD_BEEF two cycles after accept.
  - Expect flash_mem_address=23'h00010, end_flash_read high one cycle, audiodata=32'hDEADBEEF.
- Stall: waitrequest held high 5 cycles.
  - Expect flash_mem_read high for 6 cycles with address stable.
  - Expect exactly one command accepted, then normal completion.
- Held start: keep start_flash=1 for 10 cycles after end_flash_read.
  - Expect no second flash_mem_read until start_flash drops and is re-raised.
- Byte mask: byteenable=4'b0011, readdata=32'hAABBCCDD.
  - Expect audiodata=32'h0000CCDD.
- Timeout: never assert readdatavalid, TIMEOUT_CYCLES=16.
  - Expect end_flash_read pulse after 16 counted cycles, timeout_err=1, audiodata equal to the previous value.
  - Next good read clears timeout_err.
- Reset mid-read: assert reset during WAIT_DATA, then send readdatavalid.
  - Expect state IDLE, all outputs at reset values, no end_flash_read pulse.
